// File: rtl/mem_port_scheduler.sv
// Purpose : arbitrates I-fill, D-fill and D-store traffic onto one pipelined memory port
//           and steers returned beats into the owning cache's data/tag arrays.
// Latency : store = 1 cycle after grant; fill = BLOCK_WORDS + MEM_LATENCY cycles after grant.
// Backpr. : requesters hold their request until done; the memory port is never stalled.
// Option  : define MEM_PORT_CRITICAL_WORD_FIRST_EN to start each fill at the missing word.
module mem_port_scheduler #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_write,
  input  logic [15:0] d_write_addr,
  input  logic [15:0] d_write_data,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_load_data,
  output logic        i_load_tag,
  output logic        d_load_data,
  output logic        d_load_tag,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  localparam int CW  = $clog2(BLOCK_WORDS);
  localparam int OFF = CW + 1;
  localparam int DW  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {DRAIN, IDLE, WRITE, FILL_I, FILL_D} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  state_t         state;
  gnt_t           last_grant;
  logic [DW-1:0]  drain_cnt;
  logic [CW-1:0]  iss_cnt;
  logic [CW-1:0]  rcv_cnt;
  logic [CW-1:0]  fill_start;
  logic [15:0]    fill_base;
  logic           issuing;

  logic           in_fill;
  logic           first_issue;
  logic           beat;
  logic           last_beat;
  logic           grant_d;
  logic           grant_i;
  logic [15:0]    sel_addr;
  logic [15:0]    sel_base;
  logic [CW-1:0]  sel_start;

  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [CW-1:0] idx);
    return base | (16'(idx) << 1);
  endfunction

  // Grant decision and block geometry of the selected miss, evaluated while IDLE
  always_comb begin
    grant_d  = !d_write && d_miss && (!i_miss || last_grant == GNT_I);
    grant_i  = !d_write && i_miss && (!d_miss || last_grant == GNT_D);
    sel_addr = grant_d ? d_miss_addr : i_miss_addr;
    sel_base = sel_addr & ~16'(2 * BLOCK_WORDS - 1);
`ifdef MEM_PORT_CRITICAL_WORD_FIRST_EN
    sel_start = sel_addr[OFF-1:1];
`else
    sel_start = '0;
`endif
  end

  // Beat acceptance and cache-side strobes; combinational so the strobe lines up with the
  // memory beat. The first fill cycle carries the first request, so a beat there is stale.
  always_comb begin
    in_fill     = (state == FILL_I) || (state == FILL_D);
    first_issue = issuing && (iss_cnt == CW'(1));
    beat        = !rst && in_fill && mem_data_valid && !first_issue;
    last_beat   = beat && (rcv_cnt == CW'(BLOCK_WORDS - 1));
    fill_data   = beat ? mem_data_in : 16'h0;
    fill_addr   = beat ? word_addr(fill_base, fill_start + rcv_cnt) : 16'h0;
    i_load_data = beat && (state == FILL_I);
    i_load_tag  = last_beat && (state == FILL_I);
    d_load_data = beat && (state == FILL_D);
    d_load_tag  = last_beat && (state == FILL_D);
    i_done      = i_load_tag;
    d_done      = d_load_tag || (!rst && state == WRITE);
    busy        = !rst && (state != IDLE);
  end

  // Scheduler FSM with registered memory-request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DRAIN;
      drain_cnt    <= DW'(MEM_LATENCY);
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      fill_start   <= '0;
      fill_base    <= 16'h0;
      issuing      <= 1'b0;
      last_grant   <= GNT_I;
      mem_enable   <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= 16'h0;
      mem_data_out <= 16'h0;
    end else begin
      case (state)
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt <= DW'(1)) state <= IDLE;
        end
        IDLE: begin
          if (d_write) begin
            state        <= WRITE;
            mem_enable   <= 1'b1;
            mem_wr       <= 1'b1;
            mem_addr     <= d_write_addr;
            mem_data_out <= d_write_data;
          end else if (grant_d || grant_i) begin
            state      <= grant_d ? FILL_D : FILL_I;
            fill_base  <= sel_base;
            fill_start <= sel_start;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= word_addr(sel_base, sel_start);
            iss_cnt    <= CW'(1);
            rcv_cnt    <= '0;
            issuing    <= 1'b1;
          end
        end
        WRITE: begin
          state        <= IDLE;
          last_grant   <= GNT_D;
          mem_enable   <= 1'b0;
          mem_wr       <= 1'b0;
          mem_addr     <= 16'h0;
          mem_data_out <= 16'h0;
        end
        FILL_I, FILL_D: begin
          // iss_cnt wraps to 0 once the whole block has been requested
          if (issuing) begin
            if (iss_cnt == '0) begin
              issuing    <= 1'b0;
              mem_enable <= 1'b0;
              mem_addr   <= 16'h0;
            end else begin
              mem_addr <= word_addr(fill_base, fill_start + iss_cnt);
              iss_cnt  <= iss_cnt + 1'b1;
            end
          end
          if (beat) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (last_beat) begin
              state      <= IDLE;
              last_grant <= (state == FILL_D) ? GNT_D : GNT_I;
            end
          end
        end
        default: state <= DRAIN;
      endcase
    end
  end

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Sequences all traffic between the I-cache and D-cache fill paths and the single shared multicycle memory port.
- Arbitrates between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Generates the memory request stream, counts returned words, and drives the per-cache data-load and tag-load strobes.
- Sits between the two caches and the memory.

Parameters:
- MEM_LATENCY, 4: cycles from an accepted memory read request to its mem_data_valid beat; memory is pipelined and accepts one request per cycle.
- BLOCK_WORDS, 8: 16-bit words per cache block; must be a power of two; block = 16 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high; one clock.
- i_miss  in  1  I-cache miss request; held until i_done.
- i_miss_addr  in  16  I-cache miss byte address.
- d_miss  in  1  D-cache miss request; held until d_done.
- d_miss_addr  in  16  D-cache miss byte address.
- d_write  in  1  D-cache store request; held until d_done.
- d_write_addr  in  16  store byte address.
- d_write_data  in  16  store data.
- mem_data_in  in  16  memory read data.
- mem_data_valid  in  1  memory read beat valid.
- mem_enable  out  1  memory request strobe.
- mem_wr  out  1  1 = write request, 0 = read request.
- mem_addr  out  16  memory request address.
- mem_data_out  out  16  memory write data.
- fill_addr  out  16  word address of the current returned beat; shared by both caches.
- fill_data  out  16  returned beat data; shared by both caches.
- i_load_data  out  1  I-cache data-array write strobe.
- i_load_tag  out  1  I-cache tag-array write strobe.
- d_load_data  out  1  D-cache data-array write strobe.
- d_load_tag  out  1  D-cache tag-array write strobe.
- i_done  out  1  one-cycle pulse when the I fill completes.
- d_done  out  1  one-cycle pulse when the D fill or store completes.
- busy  out  1  scheduler not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = DRAIN, drain counter = MEM_LATENCY.
  - Issue and receive counters = 0.
  - last_grant = I.
- States: DRAIN, IDLE, WRITE, FILL_I, FILL_D.
- DRAIN:
  - Ignore mem_data_valid.
  - Decrement the drain counter each cycle; go to IDLE when it reaches 0.
  - Purpose: discard beats still in flight from before reset.
- IDLE grant (sampled in IDLE, grant takes effect the next cycle):
  - d_write has highest priority and goes to WRITE.
  - Otherwise, if d_miss and i_miss are both set, grant the requester not granted last (round-robin on last_grant).
  - Otherwise grant the single pending miss.
  - d_write together with d_miss is illegal; d_write wins.
- WRITE:
  - One cycle with mem_enable=1, mem_wr=1, mem_addr=d_write_addr, mem_data_out=d_write_data.
  - d_done pulses in the same cycle.
  - Next state IDLE; last_grant = D.
- FILL_x (x = I or D):
  - Block base = {miss_addr[15:4], 4'h0}, latched at grant.
  - Issue phase: for issue count k = 0..BLOCK_WORDS-1, drive mem_enable=1, mem_wr=0, mem_addr = base + 2*k, one per cycle on consecutive cycles.
  - mem_enable=0 once all BLOCK_WORDS requests have issued.
  - Each mem_data_valid beat: fill_data = mem_data_in, fill_addr = base + 2*r (r = receive count), x_load_data=1, r increments.
  - Final beat (r = BLOCK_WORDS-1): x_load_tag=1 together with x_load_data, x_done pulses in the same cycle, next state IDLE, last_grant = x.
  - mem_data_valid before the first issue is ignored.
- Counters are 3 bits wide for BLOCK_WORDS=8 (log2 BLOCK_WORDS) and wrap to 0 after the final beat. Address adds are mod 2^16; the block base is 16-byte aligned, so adds never carry past the block.
- With default parameters, a fill takes BLOCK_WORDS + MEM_LATENCY = 12 cycles in FILL_x; the final beat arrives MEM_LATENCY cycles after the last issue.
- Requests arriving or changing during FILL_x or WRITE are not sampled until the return to IDLE; miss_addr is latched at grant.
- busy = (state != IDLE).
- rst asserted mid-fill: next cycle enters DRAIN. No load strobes and no done pulse for the aborted fill.

Optional Feature:
- Macro: MEM_PORT_CRITICAL_WORD_FIRST_EN.
- Defined: issue order starts at the missing word. Start index s = miss_addr[3:1]; address k = base + 2*((s+k) mod BLOCK_WORDS), wrapping within the block. fill_addr follows the same order. x_load_tag is still asserted on the BLOCK_WORDS-th beat.
- Undefined: issue order always starts at word 0 of the block, as specified above.

Test Plan:
- Reset release: rst high for 2 cycles, then low with mem_data_valid forced to 1 for 4 cycles -> no load strobes, busy=1 through DRAIN, then busy=0.
- I fill: i_miss=1, i_miss_addr=0x0126 in IDLE.
  - mem_addr sequence 0x0120, 0x0122, ..., 0x012E on 8 consecutive cycles.
  - 8 i_load_data beats with matching fill_addr; i_load_tag and i_done on beat 8, 12 cycles after the grant.
  - No d_* strobes.
- Store: d_write=1, addr 0x4000, data 0xBEEF -> one cycle mem_enable=1, mem_wr=1, mem_addr=0x4000, mem_data_out=0xBEEF, d_done=1, then IDLE.
- Contention: i_miss and d_miss raised together after reset (last_grant=I) -> D fill serviced first, then I fill. Raise both again after that -> D fill serviced first (last grant was I).
- Reset mid-fill: rst pulse at D-fill beat 3 -> no d_load_tag or d_done; DRAIN for 4 cycles; a held d_miss is re-serviced from word 0.
- With MEM_PORT_CRITICAL_WORD_FIRST_EN: i_miss_addr=0x012C -> mem_addr order 0x012C, 0x012E, 0x0120, ..., 0x012A; i_load_tag on beat 8 (fill_addr 0x012A).
